hazard_fwd_ctrl: RTL and testbench
==================================

Name: hazard_fwd_ctrl

Overview:
- Pipeline sequencer for the 5-stage ARM core (IF/ID/EX/MEM/WB).
- Keeps its own scoreboard of in-flight destination registers for the EX, MEM and WB stages.
- From the scoreboard it drives the S_PA/S_PB/S_PD select lines of the operand forwarding muxes, and detects load-use hazards (stall plus bubble).
- Sequences the branch flush. It is the single owner of the PC, IF/ID and ID/EX control enables.

Parameters:
- REG_W, 5, register index width (ARM uses indices 0-15; upper bit reserved).
- BR_FLUSH, 1, number of cycles IF/ID is cleared after a taken branch (1..3).

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rn  in  REG_W  ID source register for port A.
- id_rm  in  REG_W  ID source register for port B.
- id_rd_src  in  REG_W  ID source register for port D (store data / shift register).
- id_use_a, id_use_b, id_use_d  in  1 each  the ID instruction actually reads that port.
- id_rd  in  REG_W  ID destination register.
- id_rf_enable  in  1  the ID instruction writes the register file (ID_RF_enable).
- id_load_instr  in  1  the ID instruction is a load.
- branch_taken  in  1  EX-stage condition handler resolved a taken B/BL.
- S_PA, S_PB, S_PD  out  2 each  forwarding selects: 00 = RF, 01 = EX, 10 = MEM, 11 = WB.
- stall  out  1  load-use stall this cycle.
- flush  out  1  branch flush active this cycle.
- pc_le  out  1  PC load enable.
- ifid_le  out  1  IF/ID register load enable.
- ifid_clr  out  1  IF/ID register clear (NOP insert).
- idex_clr  out  1  ID/EX register clear (bubble insert).

Behaviour:
- Scoreboard: three registered entries, ex/mem/wb, each holding {rd[REG_W], wr, ld}.
- Each rising edge: wb<=mem, mem<=ex, ex<=new entry.
  - New entry = {id_rd, id_rf_enable, id_load_instr}.
  - New entry is forced to {0,0,0} (bubble) when idex_clr=1.
- Reset (reset=0, asynchronous):
  - All entries cleared (wr=0, ld=0); FSM enters RUN; flush counter = 0.
  - Outputs while in reset: S_*=00, stall=0, flush=0, pc_le=1, ifid_le=1, ifid_clr=0, idex_clr=0.
- Forwarding (combinational from ID inputs and the scoreboard), per port X in {A, B, D}:
  - If use_X=0, select 00.
  - Otherwise priority EX > MEM > WB: the first stage with wr=1 and rd == source register gives 01/10/11.
  - If no stage matches, select 00.
  - EX forwarding is suppressed when ex.ld=1; that case is a stall instead.
- Load-use stall: stall=1 when ex.wr and ex.ld are both set and ex.rd equals any used source register. During a stall:
  - pc_le=0, ifid_le=0, idex_clr=1.
  - Result: 1-cycle bubble. On the next cycle the load is in MEM and the select is 10.
- FSM states RUN and FLUSH:
  - RUN, branch_taken=1: flush=1, ifid_clr=1, idex_clr=1, pc_le=1, ifid_le=1, stall=0. Branch has priority over stall. If BR_FLUSH>1, go to FLUSH with cnt=BR_FLUSH-1; otherwise stay in RUN.
  - FLUSH: flush=1, ifid_clr=1, idex_clr=1, stall forced to 0, and ID inputs are ignored (S_*=00). cnt decrements each cycle; at cnt==1 return to RUN.
  - branch_taken in FLUSH is ignored; the squashed path cannot branch.
- Simultaneous conditions:
  - stall and branch_taken: the flush wins.
  - Writes to the same rd in EX and MEM: EX wins (youngest producer).
  - Reset mid-FLUSH: returns to RUN and empties the scoreboard immediately.
- Register index 15 is forwarded like any other register; PC-read handling is owned by the datapath.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined, adds:
  - Two 16-bit saturating counters: stall_cnt (increments each cycle stall=1) and flush_cnt (increments on each RUN->flush entry, not on each flush cycle).
  - Outputs stall_cnt_o and flush_cnt_o.
  - Counters are cleared by reset and saturate at 16'hFFFF.
- When undefined, the counters and those ports are absent; all other behaviour is identical.

Test Plan:
- Reset low for 3 ns, then high, with no writes in flight: S_PA=S_PB=S_PD=00, pc_le=1, stall=0, flush=0.
- ADD R1 (wr, id_rd=1), then an instruction reading id_rn=1 next cycle: S_PA=01. One cycle later with id_rn=1: S_PA=10. One cycle after that: S_PA=11. A fourth cycle gives 00.
- LDR R2 followed immediately by an instruction with id_rm=2, id_use_b=1:
  - Cycle 1: stall=1, pc_le=0, ifid_le=0, idex_clr=1.
  - Next cycle: stall=0, S_PB=10.
- Back-to-back writes to R3 (both in EX and MEM) with id_rd_src=3, id_use_d=1: S_PD=01. Same case with id_use_d=0: S_PD=00.
- BR_FLUSH=2, branch_taken pulse in RUN: flush=1, ifid_clr=1, idex_clr=1 for exactly 2 cycles; stall stays 0 even with a load-use pattern on the ID inputs; then RUN.
- Assert reset mid-FLUSH and with a load in EX: flush and stall drop immediately; after release the scoreboard is empty (S_*=00).
- With HAZARD_STATS_EN, 2 stalls and 1 flush: stall_cnt_o=2, flush_cnt_o=1.

Source files
------------

// File: rtl/hazard_fwd_ctrl_if.sv
// Hazard/forwarding controller bus: ID-stage operand info and branch resolution in,
// forwarding selects and pipeline enables out. The controller uses the slave modport.
interface hazard_fwd_ctrl_if #(
    parameter int unsigned REG_W = 5
);
    logic [REG_W-1:0] id_rn;
    logic [REG_W-1:0] id_rm;
    logic [REG_W-1:0] id_rd_src;
    logic             id_use_a;
    logic             id_use_b;
    logic             id_use_d;
    logic [REG_W-1:0] id_rd;
    logic             id_rf_enable;
    logic             id_load_instr;
    logic             branch_taken;

    logic [1:0]       S_PA;
    logic [1:0]       S_PB;
    logic [1:0]       S_PD;
    logic             stall;
    logic             flush;
    logic             pc_le;
    logic             ifid_le;
    logic             ifid_clr;
    logic             idex_clr;

    modport master (
        output id_rn, id_rm, id_rd_src, id_use_a, id_use_b, id_use_d,
        output id_rd, id_rf_enable, id_load_instr, branch_taken,
        input  S_PA, S_PB, S_PD, stall, flush, pc_le, ifid_le, ifid_clr, idex_clr
    );

    modport slave (
        input  id_rn, id_rm, id_rd_src, id_use_a, id_use_b, id_use_d,
        input  id_rd, id_rf_enable, id_load_instr, branch_taken,
        output S_PA, S_PB, S_PD, stall, flush, pc_le, ifid_le, ifid_clr, idex_clr
    );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Pipeline sequencer for the 5-stage core: tracks in-flight destinations for EX/MEM/WB,
// drives the operand forwarding selects, inserts load-use bubbles and sequences the
// branch flush. Owns PC, IF/ID and ID/EX enables.
// Optional: define HAZARD_STATS_EN to add saturating stall/flush event counters.
module hazard_fwd_ctrl #(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned BR_FLUSH = 1  // IF/ID clear cycles after a taken branch, 1..3
) (
    input  logic             clk,
    input  logic             reset,
    hazard_fwd_ctrl_if.slave bus
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]      stall_cnt_o,
    output logic [15:0]      flush_cnt_o
`endif
);

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             wr;
        logic             ld;
    } sb_entry_t;

    typedef enum logic [0:0] {
        StRun,
        StFlush
    } state_e;

    sb_entry_t  ex_q, mem_q, wb_q, ex_d;
    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;

    logic [1:0] sel_a, sel_b, sel_d;
    logic       load_use;

    logic [1:0] s_pa_c, s_pb_c, s_pd_c;
    logic       stall_c, flush_c, pc_le_c, ifid_le_c, ifid_clr_c, idex_clr_c;

    // Youngest matching producer wins; a load still in EX has no data yet, so it is
    // skipped here and handled as a stall.
    function automatic logic [1:0] fwd_sel(input logic             use_x,
                                           input logic [REG_W-1:0] src,
                                           input sb_entry_t        ex,
                                           input sb_entry_t        mem,
                                           input sb_entry_t        wb);
        logic [1:0] sel;
        sel = 2'b00;
        if (use_x) begin
            if (ex.wr && !ex.ld && (ex.rd == src)) begin
                sel = 2'b01;
            end else if (mem.wr && (mem.rd == src)) begin
                sel = 2'b10;
            end else if (wb.wr && (wb.rd == src)) begin
                sel = 2'b11;
            end
        end
        return sel;
    endfunction

    // Raw forwarding selects and load-use detection from ID sources vs. scoreboard.
    always_comb begin
        sel_a    = fwd_sel(bus.id_use_a, bus.id_rn, ex_q, mem_q, wb_q);
        sel_b    = fwd_sel(bus.id_use_b, bus.id_rm, ex_q, mem_q, wb_q);
        sel_d    = fwd_sel(bus.id_use_d, bus.id_rd_src, ex_q, mem_q, wb_q);
        load_use = ex_q.wr && ex_q.ld &&
                   ((bus.id_use_a && (ex_q.rd == bus.id_rn)) ||
                    (bus.id_use_b && (ex_q.rd == bus.id_rm)) ||
                    (bus.id_use_d && (ex_q.rd == bus.id_rd_src)));
    end

    // Flush sequencer next state and all pipeline control outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        s_pa_c     = sel_a;
        s_pb_c     = sel_b;
        s_pd_c     = sel_d;
        stall_c    = 1'b0;
        flush_c    = 1'b0;
        pc_le_c    = 1'b1;
        ifid_le_c  = 1'b1;
        ifid_clr_c = 1'b0;
        idex_clr_c = 1'b0;

        case (state_q)
            StRun: begin
                if (bus.branch_taken) begin
                    // Branch beats a simultaneous load-use: the stalled instruction dies anyway.
                    flush_c    = 1'b1;
                    ifid_clr_c = 1'b1;
                    idex_clr_c = 1'b1;
                    if (BR_FLUSH > 1) begin
                        state_d = StFlush;
                        cnt_d   = 2'(BR_FLUSH - 1);
                    end
                end else if (load_use) begin
                    stall_c    = 1'b1;
                    pc_le_c    = 1'b0;
                    ifid_le_c  = 1'b0;
                    idex_clr_c = 1'b1;
                end
            end
            StFlush: begin
                // ID holds a squashed instruction: ignore its operands and any branch.
                flush_c    = 1'b1;
                ifid_clr_c = 1'b1;
                idex_clr_c = 1'b1;
                s_pa_c     = 2'b00;
                s_pb_c     = 2'b00;
                s_pd_c     = 2'b00;
                cnt_d      = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase

        // Quiet, free-running outputs while reset is held.
        if (!reset) begin
            s_pa_c     = 2'b00;
            s_pb_c     = 2'b00;
            s_pd_c     = 2'b00;
            stall_c    = 1'b0;
            flush_c    = 1'b0;
            pc_le_c    = 1'b1;
            ifid_le_c  = 1'b1;
            ifid_clr_c = 1'b0;
            idex_clr_c = 1'b0;
        end
    end

    // New EX scoreboard entry; a bubble whenever ID/EX is cleared.
    always_comb begin
        ex_d = '0;
        if (!idex_clr_c) begin
            ex_d.rd = bus.id_rd;
            ex_d.wr = bus.id_rf_enable;
            ex_d.ld = bus.id_load_instr;
        end
    end

    // Scoreboard shift and sequencer state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StRun;
            cnt_q   <= '0;
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
        end
    end

    assign bus.S_PA     = s_pa_c;
    assign bus.S_PB     = s_pb_c;
    assign bus.S_PD     = s_pd_c;
    assign bus.stall    = stall_c;
    assign bus.flush    = flush_c;
    assign bus.pc_le    = pc_le_c;
    assign bus.ifid_le  = ifid_le_c;
    assign bus.ifid_clr = ifid_clr_c;
    assign bus.idex_clr = idex_clr_c;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_q, flush_cnt_q;
    logic        flush_entry;

    // Count flush episodes, not flush cycles.
    assign flush_entry = (state_q == StRun) && bus.branch_taken;

    // Saturating event counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_c && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (flush_entry && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: directed scenarios plus randomized traffic
// against a queue-based pipeline model.
module tb_hazard_fwd_ctrl;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned BR_FLUSH = 2;

    logic clk = 1'b0;
    logic reset;
    always #10 clk = ~clk;

    hazard_fwd_ctrl_if #(.REG_W(REG_W)) bus ();

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_o, flush_cnt_o;
`endif

    hazard_fwd_ctrl #(
        .REG_W   (REG_W),
        .BR_FLUSH(BR_FLUSH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt_o(stall_cnt_o),
        .flush_cnt_o(flush_cnt_o)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model: pipe[0]=EX, [1]=MEM, [2]=WB instructions in flight.
    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             wr;
        logic             ld;
    } ent_t;

    ent_t pipe[$];
    int   flush_left;
    int   m_stalls;
    int   m_flushes;

    logic [1:0] exp_sa, exp_sb, exp_sd;
    logic       exp_stall, exp_flush, exp_pcle, exp_ifidle, exp_ifidclr, exp_idexclr;

    function automatic logic [1:0] ref_sel(input logic use_x, input logic [REG_W-1:0] src);
        if (!use_x) return 2'b00;
        for (int k = 0; k < 3; k++) begin
            if (pipe[k].wr && pipe[k].rd == src && !(k == 0 && pipe[k].ld)) return 2'(k + 1);
        end
        return 2'b00;
    endfunction

    task automatic model_reset();
        pipe.delete();
        repeat (3) pipe.push_back('0);
        flush_left = 0;
        m_stalls   = 0;
        m_flushes  = 0;
    endtask

    task automatic model_eval();
        bit flushing, hazard;
        flushing = (flush_left > 0) || bus.branch_taken;
        hazard = pipe[0].wr && pipe[0].ld &&
                 ((bus.id_use_a && pipe[0].rd == bus.id_rn) ||
                  (bus.id_use_b && pipe[0].rd == bus.id_rm) ||
                  (bus.id_use_d && pipe[0].rd == bus.id_rd_src));
        exp_flush   = flushing;
        exp_stall   = hazard && !flushing;
        exp_pcle    = !exp_stall;
        exp_ifidle  = !exp_stall;
        exp_ifidclr = flushing;
        exp_idexclr = flushing || exp_stall;
        exp_sa = (flush_left > 0) ? 2'b00 : ref_sel(bus.id_use_a, bus.id_rn);
        exp_sb = (flush_left > 0) ? 2'b00 : ref_sel(bus.id_use_b, bus.id_rm);
        exp_sd = (flush_left > 0) ? 2'b00 : ref_sel(bus.id_use_d, bus.id_rd_src);
        if (!reset) begin
            {exp_sa, exp_sb, exp_sd} = '0;
            {exp_stall, exp_flush, exp_ifidclr, exp_idexclr} = '0;
            exp_pcle   = 1'b1;
            exp_ifidle = 1'b1;
        end
    endtask

    task automatic model_advance();
        ent_t n;
        if (!reset) return;
        if (exp_stall) m_stalls++;
        if (bus.branch_taken && flush_left == 0) m_flushes++;
        n = '0;
        if (!exp_idexclr) begin
            n.rd = bus.id_rd;
            n.wr = bus.id_rf_enable;
            n.ld = bus.id_load_instr;
        end
        pipe.push_front(n);
        void'(pipe.pop_back());
        if (flush_left > 0) flush_left--;
        else if (bus.branch_taken) flush_left = BR_FLUSH - 1;
    endtask

    // Close the current cycle: model sees pre-edge inputs, then the edge happens.
    task automatic finish_cycle();
        model_eval();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        finish_cycle();
    endtask

    task automatic clear_inputs();
        bus.id_rn = '0; bus.id_rm = '0; bus.id_rd_src = '0; bus.id_rd = '0;
        bus.id_use_a = 0; bus.id_use_b = 0; bus.id_use_d = 0;
        bus.id_rf_enable = 0; bus.id_load_instr = 0; bus.branch_taken = 0;
    endtask

    function automatic logic [REG_W-1:0] rnd_reg();
        if ($urandom_range(0, 3) == 0) return REG_W'($urandom_range(0, 15));
        return REG_W'($urandom_range(13, 15));
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        model_reset();
        #1 reset = 1'b0;
        bus.branch_taken = 1; bus.id_use_a = 1; bus.id_use_b = 1; bus.id_use_d = 1;
        #2;
        total++;
        if ({bus.flush, bus.ifid_clr, bus.idex_clr, bus.stall} !== 4'b0000) begin
            bad++;
            $display("FAIL in_reset_ctl: got flush/ifid_clr/idex_clr/stall=%b want 0000",
                     {bus.flush, bus.ifid_clr, bus.idex_clr, bus.stall});
        end
        total++;
        if ({bus.pc_le, bus.ifid_le, bus.S_PA} !== 4'b1100) begin
            bad++;
            $display("FAIL in_reset_en: got pc_le/ifid_le/S_PA=%b want 1100",
                     {bus.pc_le, bus.ifid_le, bus.S_PA});
        end
        #1 reset = 1'b1;
        bus.branch_taken = 0;
        model_reset();
        #2;
        total++;
        if ({bus.S_PA, bus.S_PB, bus.S_PD} !== 6'b0) begin
            bad++;
            $display("FAIL reset_sel: got %b want 000000", {bus.S_PA, bus.S_PB, bus.S_PD});
        end
        total++;
        if ({bus.pc_le, bus.stall, bus.flush} !== 3'b100) begin
            bad++;
            $display("FAIL reset_ctl: got pc_le/stall/flush=%b want 100",
                     {bus.pc_le, bus.stall, bus.flush});
        end
        finish_cycle();
    endtask

    task automatic test_forward_chain();
        logic [1:0] want[4];
        want = '{2'b01, 2'b10, 2'b11, 2'b00};
        clear_inputs();
        bus.id_rd = 1; bus.id_rf_enable = 1;
        step();
        clear_inputs();
        bus.id_rn = 1; bus.id_use_a = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (bus.S_PA !== want[i]) begin
                bad++;
                $display("FAIL fwd_chain[%0d]: S_PA=%b want %b", i, bus.S_PA, want[i]);
            end
            finish_cycle();
        end
    endtask

    task automatic test_load_use();
        clear_inputs();
        bus.id_rd = 2; bus.id_rf_enable = 1; bus.id_load_instr = 1;
        step();
        clear_inputs();
        bus.id_rm = 2; bus.id_use_b = 1;
        @(negedge clk);
        total++;
        if ({bus.stall, bus.pc_le, bus.ifid_le, bus.idex_clr} !== 4'b1001) begin
            bad++;
            $display("FAIL load_use_stall: stall/pc_le/ifid_le/idex_clr=%b want 1001",
                     {bus.stall, bus.pc_le, bus.ifid_le, bus.idex_clr});
        end
        finish_cycle();
        @(negedge clk);
        total++;
        if ({bus.stall, bus.S_PB, bus.pc_le} !== 4'b0101) begin
            bad++;
            $display("FAIL load_use_after: stall/S_PB/pc_le=%b want 0101",
                     {bus.stall, bus.S_PB, bus.pc_le});
        end
        finish_cycle();
        clear_inputs();
        repeat (3) step();
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        bus.id_rd = 3; bus.id_rf_enable = 1;
        step();
        step();
        clear_inputs();
        bus.id_rd_src = 3; bus.id_use_d = 1;
        @(negedge clk);
        total++;
        if (bus.S_PD !== 2'b01) begin
            bad++;
            $display("FAIL b2b_youngest: S_PD=%b want 01", bus.S_PD);
        end
        bus.id_use_d = 0;
        #1;
        total++;
        if (bus.S_PD !== 2'b00) begin
            bad++;
            $display("FAIL b2b_unused: S_PD=%b want 00", bus.S_PD);
        end
        finish_cycle();
        clear_inputs();
        repeat (3) step();
    endtask

    task automatic test_branch_flush();
        clear_inputs();
        bus.id_rd = 4; bus.id_rf_enable = 1; bus.id_load_instr = 1;
        step();
        clear_inputs();
        bus.id_rn = 4; bus.id_use_a = 1; bus.branch_taken = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if ({bus.flush, bus.ifid_clr, bus.idex_clr, bus.stall, bus.pc_le} !== 5'b11101) begin
                bad++;
                $display("FAIL flush_cyc[%0d]: flush/ifid_clr/idex_clr/stall/pc_le=%b want 11101",
                         c, {bus.flush, bus.ifid_clr, bus.idex_clr, bus.stall, bus.pc_le});
            end
            if (c == 1) begin
                total++;
                if (bus.S_PA !== 2'b00) begin
                    bad++;
                    $display("FAIL flush_sel: S_PA=%b want 00", bus.S_PA);
                end
            end
            finish_cycle();
        end
        bus.branch_taken = 0;
        @(negedge clk);
        total++;
        if ({bus.flush, bus.ifid_clr, bus.S_PA} !== 4'b0011) begin
            bad++;
            $display("FAIL flush_end: flush/ifid_clr/S_PA=%b want 0011",
                     {bus.flush, bus.ifid_clr, bus.S_PA});
        end
        finish_cycle();
        clear_inputs();
        step();
    endtask

    task automatic test_reset_mid_flush();
        clear_inputs();
        bus.id_rd = 5; bus.id_rf_enable = 1; bus.id_load_instr = 1;
        step();
        clear_inputs();
        bus.id_rn = 5; bus.id_use_a = 1;
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        total++;
        if ({bus.stall, bus.pc_le, bus.idex_clr} !== 3'b010) begin
            bad++;
            $display("FAIL rst_stall: stall/pc_le/idex_clr=%b want 010",
                     {bus.stall, bus.pc_le, bus.idex_clr});
        end
        #1 reset = 1'b1;
        model_reset();
        finish_cycle();
        clear_inputs();
        bus.id_rd = 6; bus.id_rf_enable = 1;
        step();
        clear_inputs();
        bus.branch_taken = 1;
        step();
        bus.branch_taken = 0;
        bus.id_rn = 6; bus.id_use_a = 1;
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        total++;
        if ({bus.flush, bus.ifid_clr} !== 2'b00) begin
            bad++;
            $display("FAIL rst_flush: flush/ifid_clr=%b want 00", {bus.flush, bus.ifid_clr});
        end
        #1 reset = 1'b1;
        model_reset();
        #1;
        total++;
        if ({bus.S_PA, bus.flush} !== 3'b000) begin
            bad++;
            $display("FAIL rst_sb_empty: S_PA/flush=%b want 000", {bus.S_PA, bus.flush});
        end
        finish_cycle();
        clear_inputs();
    endtask

    task automatic test_random();
        logic [5:0] exp_sel, obs_sel, exp_ctl, obs_ctl;
        for (int i = 0; i < 400; i++) begin
            bus.id_rn         = rnd_reg();
            bus.id_rm         = rnd_reg();
            bus.id_rd_src     = rnd_reg();
            bus.id_rd         = rnd_reg();
            bus.id_use_a      = 1'($urandom_range(0, 1));
            bus.id_use_b      = 1'($urandom_range(0, 1));
            bus.id_use_d      = 1'($urandom_range(0, 1));
            bus.id_rf_enable  = 1'($urandom_range(0, 1));
            bus.id_load_instr = 1'($urandom_range(0, 1));
            bus.branch_taken  = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            model_eval();
            exp_sel = {exp_sa, exp_sb, exp_sd};
            obs_sel = {bus.S_PA, bus.S_PB, bus.S_PD};
            exp_ctl = {exp_stall, exp_flush, exp_pcle, exp_ifidle, exp_ifidclr, exp_idexclr};
            obs_ctl = {bus.stall, bus.flush, bus.pc_le, bus.ifid_le, bus.ifid_clr, bus.idex_clr};
            total++;
            if (obs_sel !== exp_sel) begin
                bad++;
                $display("FAIL rand_sel[%0d]: PA/PB/PD=%b want %b", i, obs_sel, exp_sel);
            end
            total++;
            if (obs_ctl !== exp_ctl) begin
                bad++;
                $display("FAIL rand_ctl[%0d]: stall/flush/pc_le/ifid_le/ifid_clr/idex_clr=%b want %b",
                         i, obs_ctl, exp_ctl);
            end
            finish_cycle();
        end
        clear_inputs();
        step();
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        clear_inputs();
        @(negedge clk);
        #1 reset = 1'b0;
        #1 reset = 1'b1;
        model_reset();
        finish_cycle();
        for (int s = 0; s < 2; s++) begin
            clear_inputs();
            bus.id_rd = 2; bus.id_rf_enable = 1; bus.id_load_instr = 1;
            step();
            clear_inputs();
            bus.id_rm = 2; bus.id_use_b = 1;
            step();
            step();
        end
        clear_inputs();
        bus.branch_taken = 1;
        step();
        step();
        clear_inputs();
        step();
        total++;
        if (stall_cnt_o !== 16'd2 || m_stalls != 2) begin
            bad++;
            $display("FAIL stat_stall: stall_cnt_o=%0d want 2", stall_cnt_o);
        end
        total++;
        if (flush_cnt_o !== 16'd1 || m_flushes != 1) begin
            bad++;
            $display("FAIL stat_flush: flush_cnt_o=%0d want 1", flush_cnt_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_forward_chain();
        test_load_use();
        test_back_to_back();
        test_branch_flush();
        test_reset_mid_flush();
        test_random();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
